pipelined_adder: RTL and testbench
==================================

PIPELINED_ADDER -- requirements
Module: pipelined_adder

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 SHALL have parameter CHUNK, default 4: bits added per pipeline stage; WIDTH SHALL be an integer multiple of CHUNK.
REQ-003 SHALL have port clk, input, 1: the single clock, rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port en, input, 1: pipeline advance enable.
REQ-006 SHALL have port in_valid, input, 1: a, b and c_in are valid this cycle.
REQ-007 SHALL have port a, input, WIDTH: operand A, unsigned.
REQ-008 SHALL have port b, input, WIDTH: operand B, unsigned.
REQ-009 SHALL have port c_in, input, 1: carry in.
REQ-010 SHALL have port out_valid, output, 1: sum and c_out are valid.
REQ-011 SHALL have port sum, output, WIDTH: result.
REQ-012 SHALL have port c_out, output, 1: carry out of the MSB.

Function
REQ-013 SHALL compute {c_out, sum} = a + b + c_in with no loss of bits.
REQ-014 SHALL use STAGES = WIDTH/CHUNK pipeline stages. Stage k adds bits [k*CHUNK +: CHUNK] using the registered carry from stage k-1. Stage 0 uses c_in.
REQ-015 SHALL give a latency of exactly STAGES enabled cycles from an in_valid sample to the matching out_valid.
REQ-016 SHALL delay the operand chunks not yet added, and the sum chunks already computed, in skew registers so each result leaves the pipeline aligned.
REQ-017 SHALL accept one operation per enabled cycle, back-to-back, with no bubbles inserted.
REQ-018 SHALL freeze every pipeline register while en=0. out_valid, sum and c_out SHALL hold their values, and inputs SHALL be ignored.
REQ-019 SHALL propagate in_valid=0 as a bubble; out_valid SHALL be 0 for that slot and sum/c_out are don't-care.
REQ-020 SHALL propagate a carry across every chunk boundary within the one operation; carries SHALL never leak between consecutive operations.
REQ-021 SHALL reproduce the one-bit full-adder truth table when WIDTH=CHUNK=1, with latency 1.

Reset
REQ-022 SHALL, while rst=1, clear all pipeline registers asynchronously, giving out_valid=0, sum=0 and c_out=0.
REQ-023 SHALL discard all in-flight operations when rst is asserted mid-operation; none SHALL emerge after release.
REQ-024 SHALL accept a new operation on the first enabled rising edge after rst deasserts.

Configuration
REQ-025 SHALL define macro PIPELINED_ADDER_SATURATE_EN.
REQ-026 SHALL, when PIPELINED_ADDER_SATURATE_EN is defined and the true result exceeds 2^WIDTH-1, force sum to all ones, with c_out=1. The clamp SHALL be applied in the final stage and SHALL add no latency.
REQ-027 SHALL, when PIPELINED_ADDER_SATURATE_EN is undefined, wrap sum modulo 2^WIDTH, with c_out flagging the overflow.

Structure
REQ-028 SHALL place the default WIDTH and CHUNK constants, and the STAGES derivation function, in a shared package, adder_pkg.
REQ-029 SHALL instantiate one sub-module, adder_chunk, per stage: a registered CHUNK-bit adder with carry in, carry out and enable.
REQ-030 SHALL check WIDTH % CHUNK == 0 at elaboration and SHALL fail elaboration otherwise.

Verification (WIDTH=16, CHUNK=4, latency 4)
REQ-031 SHALL cover a carry chain: a=0x00FF, b=0x0001, c_in=0 -> 4 cycles later sum=0x0100, c_out=0, out_valid=1 for one cycle.
REQ-032 SHALL cover overflow: a=0xFFFF, b=0x0001, c_in=0 -> sum=0x0000, c_out=1 without the macro. With the macro, sum=0xFFFF, c_out=1.
REQ-033 SHALL cover back-to-back traffic: (0x1234+0x1111+0), (0x8000+0x8000+1), (0x0F0F+0x00F1+1) on consecutive cycles -> 0x2345/0, 0x0001/1, 0x1001/0 on consecutive cycles.
REQ-034 SHALL cover a stall: en=0 for 3 cycles while 2 operations are in flight -> outputs frozen, results arrive 3 cycles later, unchanged.
REQ-035 SHALL cover reset mid-operation: rst pulsed 2 cycles after an issue -> out_valid stays 0, and no stale result appears afterwards.
REQ-036 SHALL cover bubbles: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 at latency 4.

Source files
------------

// File: rtl/adder_pkg.sv
// Shared constants and the stage-count derivation for the chunked pipelined adder.
package adder_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_CHUNK = 4;

    function automatic int stages(input int width, input int chunk);
        return width / chunk;
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// One pipeline stage: a registered CHUNK-bit adder with carry in/out, frozen while en=0.
module adder_chunk #(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, ci};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
            co  <= 1'b0;
        end else if (en) begin
            {co, sum} <= total;
        end
    end

endmodule

// File: rtl/pipelined_adder.sv
// Carry-pipelined adder: WIDTH/CHUNK stages, one chunk added per stage, skewed operands and sums.
// Optional output clamp on overflow when PIPELINED_ADDER_SATURATE_EN is defined.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CHUNK = DEFAULT_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             c_out
);

    localparam int STAGES = stages(WIDTH, CHUNK);

    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
        $error("pipelined_adder: WIDTH must be a multiple of CHUNK");
    end

    // Handshake: in_valid qualifies a/b/c_in on each enabled edge; there is no backpressure.
    // en=0 freezes the whole pipe; out_valid qualifies sum/c_out exactly STAGES enabled edges later.
    logic [CHUNK-1:0]  sum_chunk [STAGES];
    logic [STAGES-1:0] carry;
    logic [STAGES-1:0] valid_r;
    logic [WIDTH-1:0]  raw_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= '0;
        end else if (en) begin
            valid_r[0] <= in_valid;
            for (int k = 1; k < STAGES; k++) begin
                valid_r[k] <= valid_r[k-1];
            end
        end
    end

    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        logic [CHUNK-1:0] a_j;
        logic [CHUNK-1:0] b_j;
        logic             ci_j;

        if (j == 0) begin : g_first
            assign a_j  = a[CHUNK-1:0];
            assign b_j  = b[CHUNK-1:0];
            assign ci_j = c_in;
        end else begin : g_skew_in
            // Operand chunk j waits j cycles so it meets the carry of its own operation.
            logic [2*CHUNK-1:0] op_sr [j];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < j; i++) begin
                        op_sr[i] <= '0;
                    end
                end else if (en) begin
                    op_sr[0] <= {a[j*CHUNK +: CHUNK], b[j*CHUNK +: CHUNK]};
                    for (int i = 1; i < j; i++) begin
                        op_sr[i] <= op_sr[i-1];
                    end
                end
            end

            assign {a_j, b_j} = op_sr[j-1];
            assign ci_j       = carry[j-1];
        end

        adder_chunk #(
            .CHUNK(CHUNK)
        ) u_chunk (
            .clk(clk),
            .rst(rst),
            .en (en),
            .a  (a_j),
            .b  (b_j),
            .ci (ci_j),
            .sum(sum_chunk[j]),
            .co (carry[j])
        );

        if (j == STAGES - 1) begin : g_last
            assign raw_sum[j*CHUNK +: CHUNK] = sum_chunk[j];
        end else begin : g_skew_out
            localparam int DEPTH = STAGES - 1 - j;
            logic [CHUNK-1:0] sum_sr [DEPTH];

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        sum_sr[i] <= '0;
                    end
                end else if (en) begin
                    sum_sr[0] <= sum_chunk[j];
                    for (int i = 1; i < DEPTH; i++) begin
                        sum_sr[i] <= sum_sr[i-1];
                    end
                end
            end

            assign raw_sum[j*CHUNK +: CHUNK] = sum_sr[DEPTH-1];
        end
    end

    assign out_valid = valid_r[STAGES-1];
    assign c_out     = carry[STAGES-1];

`ifdef PIPELINED_ADDER_SATURATE_EN
    // The final carry is the overflow flag, so clamping on it adds no register stage.
    assign sum = c_out ? {WIDTH{1'b1}} : raw_sum;
`else
    assign sum = raw_sum;
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (16/4 instance plus a 1/1 full-adder instance).
module tb_pipelined_adder;

    localparam int W   = 16;
    localparam int LAT = 4;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] sum;
        logic         co;
    } vec_t;

    typedef struct {
        logic a;
        logic b;
        logic ci;
        logic s;
        logic co;
    } fa_t;

    logic         clk = 1'b0;
    logic         rst, en, in_valid, c_in, out_valid, c_out;
    logic [W-1:0] a, b, sum;

    logic         iv1, ci1, ov1, co1;
    logic [0:0]   a1, b1, s1;

    int           n_checks = 0;
    int           n_fail   = 0;

    logic [W:0]   exp_q[$];
    logic         exp_vld [LAT];
    logic [W:0]   drv_exp;
    logic [W:0]   cur_exp;
    logic         cur_vld;

    vec_t         vecs [12];
    fa_t          fa_tab [8];

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
        .a(a), .b(b), .c_in(c_in),
        .out_valid(out_valid), .sum(sum), .c_out(c_out)
    );

    pipelined_adder #(.WIDTH(1), .CHUNK(1)) u_dut1 (
        .clk(clk), .rst(rst), .en(en), .in_valid(iv1),
        .a(a1), .b(b1), .c_in(ci1),
        .out_valid(ov1), .sum(s1), .c_out(co1)
    );

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_word(input string name, input logic [W:0] act, input logic [W:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got {c_out,sum}=%h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [W:0] expect_word(input vec_t v);
`ifdef PIPELINED_ADDER_SATURATE_EN
        if (v.co) return {1'b1, {W{1'b1}}};
`endif
        return {v.co, v.sum};
    endfunction

    task automatic clear_model();
        exp_q.delete();
        for (int i = 0; i < LAT; i++) exp_vld[i] = 1'b0;
        cur_vld = 1'b0;
    endtask

    // One clock: update the latency model on the edge, then check outputs on the falling edge.
    task automatic tick();
        logic was_en, was_iv;
        was_en = en;
        was_iv = in_valid;
        @(posedge clk);
        if (rst) begin
            clear_model();
        end else if (was_en) begin
            for (int i = LAT - 1; i > 0; i--) exp_vld[i] = exp_vld[i-1];
            exp_vld[0] = was_iv;
            if (was_iv) exp_q.push_back(drv_exp);
        end
        @(negedge clk);
        if (rst) begin
            check_bit("reset_valid", out_valid, 1'b0);
            check_word("reset_result", {c_out, sum}, '0);
        end else if (was_en) begin
            check_bit("out_valid", out_valid, exp_vld[LAT-1]);
            cur_vld = exp_vld[LAT-1];
            if (exp_vld[LAT-1]) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL result: no expectation queued at %0t", $time);
                end else begin
                    cur_exp = exp_q.pop_front();
                    check_word("result", {c_out, sum}, cur_exp);
                end
            end
        end else begin
            check_bit("hold_valid", out_valid, cur_vld);
            if (cur_vld) check_word("hold_result", {c_out, sum}, cur_exp);
        end
    endtask

    task automatic issue(input vec_t v);
        a        = v.a;
        b        = v.b;
        c_in     = v.ci;
        in_valid = 1'b1;
        drv_exp  = expect_word(v);
        tick();
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            a        = W'($urandom_range(0, 16'hFFFF));
            b        = W'($urandom_range(0, 16'hFFFF));
            c_in     = 1'($urandom_range(0, 1));
            tick();
        end
    endtask

    initial begin
        vecs[0]  = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2]  = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        vecs[3]  = '{16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1};
        vecs[4]  = '{16'h0F0F, 16'h00F1, 1'b1, 16'h1001, 1'b0};
        vecs[5]  = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
        vecs[6]  = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
        vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[8]  = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1};
        vecs[9]  = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};
        vecs[10] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
        vecs[11] = '{16'h0FFF, 16'hF001, 1'b0, 16'h0000, 1'b1};

        fa_tab[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        fa_tab[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        fa_tab[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        fa_tab[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        fa_tab[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        fa_tab[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        fa_tab[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        fa_tab[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

        // Clock/reset
        rst = 1'b1; en = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0;
        iv1 = 1'b0; a1 = '0; b1 = '0; ci1 = 1'b0; drv_exp = '0; cur_exp = '0;
        clear_model();
        #2;
        check_bit("reset_valid_async", out_valid, 1'b0);
        check_word("reset_result_async", {c_out, sum}, '0);
        tick();
        tick();
        rst = 1'b0;
        en  = 1'b1;

        // Carry chain with single-cycle out_valid pulse
        issue(vecs[0]);
        bubble(6);

        // Table: all vectors back-to-back
        for (int i = 0; i < 12; i++) issue(vecs[i]);
        bubble(6);

        // Bubbles: 1,0,1
        issue(vecs[2]);
        bubble(1);
        issue(vecs[3]);
        bubble(6);

        // Stall with two operations in flight, first one sitting at the output
        issue(vecs[4]);
        issue(vecs[10]);
        bubble(2);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            a        = W'($urandom_range(0, 16'hFFFF));
            b        = W'($urandom_range(0, 16'hFFFF));
            c_in     = 1'($urandom_range(0, 1));
            tick();
        end
        en = 1'b1;
        bubble(6);

        // Reset two cycles after an issue: nothing stale may emerge
        issue(vecs[9]);
        bubble(1);
        rst = 1'b1;
        #1;
        check_bit("midop_reset_valid", out_valid, 1'b0);
        check_word("midop_reset_result", {c_out, sum}, '0);
        clear_model();
        tick();
        rst = 1'b0;
        issue(vecs[11]);
        bubble(7);

        // One-bit full adder, latency 1
        for (int i = 0; i < 8; i++) begin
            logic exp_s;
            iv1 = 1'b1;
            a1  = fa_tab[i].a;
            b1  = fa_tab[i].b;
            ci1 = fa_tab[i].ci;
            exp_s = fa_tab[i].s;
`ifdef PIPELINED_ADDER_SATURATE_EN
            if (fa_tab[i].co) exp_s = 1'b1;
`endif
            tick();
            check_bit("fa_valid", ov1, 1'b1);
            check_bit("fa_sum", s1[0], exp_s);
            check_bit("fa_cout", co1, fa_tab[i].co);
        end
        iv1 = 1'b0;
        tick();
        check_bit("fa_bubble_valid", ov1, 1'b0);

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d results never emerged, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
